// File: rtl/program_counter_pkg.sv
// Shared constants and next-PC source select for the instruction-fetch program counter.
package program_counter_pkg;

   localparam int unsigned      WIDTH        = 32;
   localparam logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [WIDTH-1:0] PC_INCR      = 32'd4;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JIMM,
      SEL_JREG
   } next_sel_e;

endpackage

// File: rtl/program_counter_pc_reg.sv
// WIDTH-bit PC holding register with synchronous active-high reset to RESET_VECTOR.
module program_counter_pc_reg #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VECTOR;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/program_counter.sv
// Fetch program counter: sequential, branch, immediate-jump and register-jump next-PC selection.
// Register jumps (JR/JALR) are only honoured when PC_JR_EN is defined.
module program_counter #(
   parameter int unsigned      WIDTH        = program_counter_pkg::WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = program_counter_pkg::RESET_VECTOR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      branchaddress,
   input  logic [25:0]      jumpaddress,
   input  logic             jump,
   input  logic             beq,
   input  logic             bne,
   input  logic             regorimm,
   input  logic [WIDTH-1:0] reg_rs,
   output logic [WIDTH-1:0] pcaddress,
   output logic [WIDTH-1:0] reg_31
);

   import program_counter_pkg::*;

   localparam logic [WIDTH-1:0] INCR = WIDTH'(PC_INCR);

   logic [WIDTH-1:0] seq;
   logic [WIDTH-1:0] branch_off;
   logic [WIDTH-1:0] branch_tgt;
   logic [WIDTH-1:0] jimm_tgt;
   logic [WIDTH-1:0] next_pc;
   next_sel_e        sel;

   assign seq        = pcaddress + INCR;
   assign branch_off = {{(WIDTH-18){branchaddress[15]}}, branchaddress, 2'b00};
   assign branch_tgt = seq + branch_off;
   assign jimm_tgt   = {seq[WIDTH-1:28], jumpaddress, 2'b00};
   assign reg_31     = seq;

   // Jump beats any branch; beq and bne together still mean "branch taken".
   always_comb begin
      sel = SEL_SEQ;
      if (jump) begin
`ifdef PC_JR_EN
         sel = regorimm ? SEL_JREG : SEL_JIMM;
`else
         sel = SEL_JIMM;
`endif
      end else if (beq || bne) begin
         sel = SEL_BRANCH;
      end
   end

`ifndef PC_JR_EN
   logic unused_jr;
   assign unused_jr = ^{regorimm, reg_rs};
`endif

   always_comb begin
      next_pc = seq;
      unique case (sel)
         SEL_SEQ:    next_pc = seq;
         SEL_BRANCH: next_pc = branch_tgt;
         SEL_JIMM:   next_pc = jimm_tgt;
         SEL_JREG:   next_pc = reg_rs;
      endcase
   end

   program_counter_pc_reg #(
      .WIDTH        (WIDTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) pc_reg (
      .clk   (clk),
      .reset (reset),
      .d     (next_pc),
      .q     (pcaddress)
   );

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter against an arithmetic next-PC reference model.
module tb_program_counter;

   localparam logic [31:0] RV = 32'h0000_0000;
`ifdef PC_JR_EN
   localparam bit JR_EN = 1'b1;
`else
   localparam bit JR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] branchaddress = '0;
   logic [25:0] jumpaddress = '0;
   logic        jump = 1'b0;
   logic        beq = 1'b0;
   logic        bne = 1'b0;
   logic        regorimm = 1'b0;
   logic [31:0] reg_rs = '0;
   logic [31:0] pcaddress;
   logic [31:0] reg_31;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] exp_pc;

   program_counter dut (
      .clk           (clk),
      .reset         (reset),
      .branchaddress (branchaddress),
      .jumpaddress   (jumpaddress),
      .jump          (jump),
      .beq           (beq),
      .bne           (bne),
      .regorimm      (regorimm),
      .reg_rs        (reg_rs),
      .pcaddress     (pcaddress),
      .reg_31        (reg_31)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic r, input logic j,
                                            input logic b, input logic bn, input logic roi,
                                            input logic [31:0] rs, input logic [15:0] ba,
                                            input logic [25:0] ja);
      logic [31:0] s;
      logic [31:0] off;
      if (r) return RV;
      s = pc + 32'd4;
      if (j) begin
         if (JR_EN && roi) return rs;
         return (s & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
      end
      if (b || bn) begin
         off = 32'($signed(ba)) * 32'd4;
         return s + off;
      end
      return s;
   endfunction

   task automatic step(input logic r, input logic j, input logic b, input logic bn,
                       input logic roi, input logic [31:0] rs, input logic [15:0] ba,
                       input logic [25:0] ja);
      reset = r; jump = j; beq = b; bne = bn; regorimm = roi;
      reg_rs = rs; branchaddress = ba; jumpaddress = ja;
      @(posedge clk);
      exp_pc = ref_next(exp_pc, r, j, b, bn, roi, rs, ba, ja);
      #1;
   endtask

   task automatic set_pc(input logic [31:0] target);
      logic [31:0] s;
      for (int i = 0; i < 20; i++) begin
         s = exp_pc + 32'd4;
         if (s[31:28] == target[31:28]) break;
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 26'h3FF_FFFF);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, target[27:2]);
      checks++;
      if (pcaddress !== target) begin
         errors++;
         $display("FAIL set_pc: pcaddress=%h required=%h", pcaddress, target);
      end
   endtask

   task automatic test_reset;
      logic [31:0] want [3] = '{32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
         checks++;
         if (pcaddress !== RV || reg_31 !== RV + 32'd4) begin
            errors++;
            $display("FAIL reset_hold: pc=%h link=%h required pc=%h link=%h",
                     pcaddress, reg_31, RV, RV + 32'd4);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
         checks++;
         if (pcaddress !== want[i] || reg_31 !== want[i] + 32'd4) begin
            errors++;
            $display("FAIL run_seq%0d: pc=%h link=%h required pc=%h link=%h",
                     i, pcaddress, reg_31, want[i], want[i] + 32'd4);
         end
      end
   endtask

   task automatic test_branch;
      set_pc(32'h100);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0003, '0);
      checks++;
      if (pcaddress !== 32'h110) begin
         errors++;
         $display("FAIL beq_fwd: pc=%h required=%h", pcaddress, 32'h110);
      end
      set_pc(32'h100);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 16'hFFFF, '0);
      checks++;
      if (pcaddress !== 32'h100) begin
         errors++;
         $display("FAIL bne_back: pc=%h required=%h", pcaddress, 32'h100);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 16'hFFF0, '0);
      checks++;
      if (pcaddress !== 32'h0C4) begin
         errors++;
         $display("FAIL beq_bne_both: pc=%h required=%h", pcaddress, 32'h0C4);
      end
   endtask

   task automatic test_jump;
      set_pc(32'h1000_0000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 26'h000_0040);
      checks++;
      if (pcaddress !== 32'h1000_0100) begin
         errors++;
         $display("FAIL jump_imm: pc=%h required=%h", pcaddress, 32'h1000_0100);
      end
      set_pc(32'h1000_0000);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0010, 26'h000_0040);
      checks++;
      if (pcaddress !== 32'h1000_0100) begin
         errors++;
         $display("FAIL jump_over_beq: pc=%h required=%h", pcaddress, 32'h1000_0100);
      end
   endtask

   task automatic test_jreg;
      logic [31:0] want;
      set_pc(32'h0000_0800);
      want = JR_EN ? 32'h0000_2468 : 32'h0000_0100;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2468, '0, 26'h000_0040);
      checks++;
      if (pcaddress !== want) begin
         errors++;
         $display("FAIL jump_reg: pc=%h required=%h", pcaddress, want);
      end
   endtask

   task automatic test_wrap_reset;
      set_pc(32'hFFFF_FFFC);
      checks++;
      if (reg_31 !== 32'h0000_0000) begin
         errors++;
         $display("FAIL link_wrap: link=%h required=%h", reg_31, 32'h0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (pcaddress !== 32'h0000_0000) begin
         errors++;
         $display("FAIL pc_wrap: pc=%h required=%h", pcaddress, 32'h0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 16'h0100, 26'h3FF_FFFF);
      checks++;
      if (pcaddress !== RV) begin
         errors++;
         $display("FAIL reset_priority: pc=%h required=%h", pcaddress, RV);
      end
      // Release edge loads the jump target computed from the reset-vector base.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 26'h000_0005);
      checks++;
      if (pcaddress !== 32'h0000_0014) begin
         errors++;
         $display("FAIL reset_release: pc=%h required=%h", pcaddress, 32'h14);
      end
   endtask

   task automatic test_random;
      logic r, j, b, bn, roi;
      for (int i = 0; i < 300; i++) begin
         r   = ($urandom_range(15) == 0);
         j   = ($urandom_range(3) == 0);
         b   = ($urandom_range(3) == 0);
         bn  = ($urandom_range(3) == 0);
         roi = $urandom_range(1) == 1;
         step(r, j, b, bn, roi, $urandom & 32'hFFFF_FFFC, 16'($urandom), 26'($urandom));
         checks++;
         if (pcaddress !== exp_pc || reg_31 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL random%0d: pc=%h link=%h required pc=%h link=%h",
                     i, pcaddress, reg_31, exp_pc, exp_pc + 32'd4);
         end
      end
   endtask

   initial begin
      exp_pc = RV;
      test_reset();
      test_branch();
      test_jump();
      test_jreg();
      test_wrap_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
